// File: rtl/jtframe_psram_model_pkg.sv
// Shared types and constants for the PSRAM pin-side responder.
package jtframe_psram_pkg;

  localparam int PSRAM_AHI = 6;   // upper address bits carried on psram_addr
  localparam int PSRAM_DW  = 16;  // ADQ bus / array word width

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    READ,
    WRITE
  } psram_state_t;

endpackage

// File: rtl/jtframe_psram_model_if.sv
// PSRAM pin bundle: the controller is the master, the emulated chip is the slave.
interface jtframe_psram_model_if;

  logic [1:0]                              psram_cen;
  logic [jtframe_psram_pkg::PSRAM_AHI-1:0] psram_addr;
  logic [jtframe_psram_pkg::PSRAM_DW-1:0]  adq_in;
  logic [jtframe_psram_pkg::PSRAM_DW-1:0]  adq_out;
  logic                                    adq_oe;
  logic [1:0]                              psram_dsn;
  logic                                    psram_oen;
  logic                                    psram_wen;

  modport master (
    output psram_cen, psram_addr, adq_in, psram_dsn, psram_oen, psram_wen,
    input  adq_out, adq_oe
  );

  modport slave (
    input  psram_cen, psram_addr, adq_in, psram_dsn, psram_oen, psram_wen,
    output adq_out, adq_oe
  );

endinterface

// File: rtl/jtframe_psram_model_mem.sv
// 2^AW x 16 word array: byte-enable pin write port A, preload port B,
// synchronous read. Port B wins when both ports write in the same cycle.
module jtframe_psram_model_mem
  import jtframe_psram_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic                clk,
  input  logic                a_we,
  input  logic [1:0]          a_be,
  input  logic [AW-1:0]       a_addr,
  input  logic [PSRAM_DW-1:0] a_data,
  input  logic                b_we,
  input  logic [AW-1:0]       b_addr,
  input  logic [PSRAM_DW-1:0] b_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [PSRAM_DW-1:0] rd_data
);

  logic [PSRAM_DW-1:0] mem [0:2**AW-1];

  // Array writes (preload first) and registered read.
  // NOTE: the array has no reset branch on purpose; clearing a RAM costs a
  // loop of writes and keeps it from mapping onto block memory. Non-blocking
  // assignments keep the read returning the pre-write word when the same
  // address is written in that cycle.
  always_ff @(posedge clk) begin
    if (b_we) begin
      mem[b_addr] <= b_data;
    end else if (a_we) begin
      if (a_be[0]) mem[a_addr][7:0]  <= a_data[7:0];
      if (a_be[1]) mem[a_addr][15:8] <= a_data[15:8];
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/jtframe_psram_model.sv
// Chip-side responder for the async, address/data multiplexed PSRAM pins.
// Every data phase is preceded by address cycles (oen=wen=1); reads drive
// ADQ after RD_LAT cycles, writes commit byte-wise when wen rises.
module jtframe_psram_model
  import jtframe_psram_pkg::*;
#(
  parameter int CHIP   = 0,
  parameter int AW     = 12,
  parameter int RD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  jtframe_psram_model_if.slave   pin,
  input  logic [AW-1:0]          prog_addr,
  input  logic [PSRAM_DW-1:0]    prog_data,
  input  logic                   prog_we,
  output logic                   err
);

  localparam bit       CHIP_B = CHIP[0];
  localparam logic [2:0] LAT    = 3'(RD_LAT);
  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  psram_state_t                 state_q, state_d;
  logic [AW-1:0]                addr_q;
  logic [2:0]                   cnt_q;
  logic [PSRAM_DW-1:0]          wdata_q;
  logic [1:0]                   be_q;
  logic [PSRAM_DW-1:0]          rd_data;
  logic [PSRAM_AHI+PSRAM_DW-1:0] full_addr;
  logic                         sel, both_low, unused_addr;
  logic                         addr_lat, wcap, commit, rd_act, rd_enter, err_set;

  assign sel         = ~pin.psram_cen[CHIP_B];
  assign both_low    = ~pin.psram_oen & ~pin.psram_wen;
  assign full_addr   = {pin.psram_addr, pin.adq_in};
  // Address bits above AW alias; fold the whole bus so nothing looks dangling.
  assign unused_addr = ^full_addr;

  // Next state and per-cycle strobes.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_lat = state_q == ADDR && sel && pin.psram_oen && pin.psram_wen;
    wcap     = (state_q == ADDR || state_q == WRITE) && sel &&
               pin.psram_oen && !pin.psram_wen;
    commit   = state_q == WRITE && !both_low && (!sel || pin.psram_wen);
    rd_act   = state_q == READ && sel && !pin.psram_oen && pin.psram_wen;
    if (!both_low) begin
      unique case (state_q)
        IDLE:  if (sel && pin.psram_oen && pin.psram_wen) state_d = ADDR;
        ADDR:  if (!sel)                state_d = IDLE;
               else if (!pin.psram_oen) state_d = READ;
               else if (!pin.psram_wen) state_d = WRITE;
        READ:  if (!sel)                state_d = IDLE;
               else if (pin.psram_oen)  state_d = ADDR;
        WRITE: if (!sel)                state_d = IDLE;
               else if (pin.psram_wen)  state_d = pin.psram_oen ? ADDR : IDLE;
      endcase
    end
    rd_enter = state_q == ADDR && state_d == READ;
    err_set  = both_low || pin.psram_cen == 2'b00 ||
               (state_q == IDLE && sel && (!pin.psram_oen || !pin.psram_wen)) ||
               (commit && prog_we);
  end

  // State register, address latch, write capture and read pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      pin.adq_out <= '0;
      pin.adq_oe  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (addr_lat) addr_q <= full_addr[AW-1:0];
      if (rd_enter)                   cnt_q <= '0;
      else if (rd_act && cnt_q != LAT) cnt_q <= cnt_q + 3'd1;
      if (rd_act && cnt_q == LAT_M1) pin.adq_out <= rd_data;
      pin.adq_oe <= rd_act && cnt_q == LAT;
      if (wcap) begin
        wdata_q <= pin.adq_in;
        be_q    <= ~pin.psram_dsn;
      end
    end
  end

  // Sticky protocol-violation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  jtframe_psram_model_mem #(.AW(AW)) u_mem (
    .clk     (clk),
    .a_we    (commit && !prog_we),
    .a_be    (be_q),
    .a_addr  (addr_q),
    .a_data  (wdata_q),
    .b_we    (prog_we),
    .b_addr  (prog_addr),
    .b_data  (prog_data),
    .rd_addr (addr_q),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_jtframe_psram_model.sv
// Directed + random bench for jtframe_psram_model against a word-array model.
module tb_jtframe_psram_model;

  localparam int AW     = 12;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [15:0]   prog_data = '0;
  logic          prog_we = 1'b0;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mdl [0:2**AW-1];

  jtframe_psram_model_if pin();

  jtframe_psram_model #(.CHIP(0), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pin       (pin),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_we   (prog_we),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] dsn);
    merge[15:8] = dsn[1] ? old[15:8] : d[15:8];
    merge[7:0]  = dsn[0] ? old[7:0]  : d[7:0];
  endfunction

  task automatic idle_cyc(input int n);
    pin.psram_cen = 2'b11;
    pin.psram_oen = 1'b1;
    pin.psram_wen = 1'b1;
    pin.psram_dsn = 2'b11;
    repeat (n) @(negedge clk);
  endtask

  task automatic addr_ph(input logic [21:0] a);
    pin.psram_cen  = 2'b10;
    pin.psram_oen  = 1'b1;
    pin.psram_wen  = 1'b1;
    pin.psram_addr = a[21:16];
    pin.adq_in     = a[15:0];
    repeat (2) @(negedge clk);
  endtask

  task automatic do_read(input logic [21:0] a, input string tag);
    logic [15:0] exp;
    exp = mdl[a[AW-1:0]];
    addr_ph(a);
    pin.psram_oen = 1'b0;
    pin.adq_in    = 16'($urandom);
    for (int k = 0; k < RD_LAT + 2; k++) begin
      @(negedge clk);
      check({tag, "_oe"}, 16'(pin.adq_oe), (k >= RD_LAT + 1) ? 16'd1 : 16'd0);
      if (k >= RD_LAT + 1) check({tag, "_data"}, pin.adq_out, exp);
    end
    pin.psram_oen = 1'b1;
    @(negedge clk);
    check({tag, "_oe_off"}, 16'(pin.adq_oe), 16'd0);
  endtask

  task automatic do_write(input logic [21:0] a, input logic [15:0] d, input logic [1:0] dsn);
    addr_ph(a);
    pin.psram_wen = 1'b0;
    pin.adq_in    = 16'($urandom);   // overwritten by the next sample
    pin.psram_dsn = 2'($urandom);
    @(negedge clk);
    pin.adq_in    = d;
    pin.psram_dsn = dsn;
    @(negedge clk);
    pin.psram_wen = 1'b1;
    pin.psram_dsn = 2'b11;
    @(negedge clk);
    mdl[a[AW-1:0]] = merge(mdl[a[AW-1:0]], d, dsn);
  endtask

  initial begin
    logic [21:0] a;
    logic [15:0] d;
    logic [1:0]  dsn;

    pin.psram_addr = '0;
    pin.adq_in     = '0;
    idle_cyc(3);
    check("rst_oe",  16'(pin.adq_oe), 16'd0);
    check("rst_out", pin.adq_out,     16'd0);
    check("rst_err", 16'(err),        16'd0);
    rst_n = 1'b1;
    idle_cyc(2);

    // Fill the whole array so every later read has a defined expectation.
    for (int i = 0; i < 2**AW; i++) begin
      prog_we   = 1'b1;
      prog_addr = AW'(i);
      prog_data = 16'($urandom);
      mdl[i]    = prog_data;
      @(negedge clk);
    end
    prog_we   = 1'b1;
    prog_addr = AW'(12'h123);
    prog_data = 16'hBEEF;
    mdl[12'h123] = 16'hBEEF;
    @(negedge clk);
    prog_we = 1'b0;
    idle_cyc(1);

    do_read(22'h000123, "preload");
    check("preload_val", mdl[12'h123], 16'hBEEF);
    check("preload_err", 16'(err), 16'd0);
    idle_cyc(1);

    do_write(22'h000045, 16'h1234, 2'b00);
    do_read(22'h000045, "wr_full");
    idle_cyc(1);
    do_write(22'h000045, 16'hAB00, 2'b01);
    do_read(22'h000045, "wr_upper");
    check("wr_upper_val", mdl[12'h045], 16'hAB34);
    idle_cyc(1);

    // Select held low across consecutive accesses.
    do_read (22'h000010, "b2b_rd0");
    do_write(22'h000011, 16'h5555, 2'b00);
    do_read (22'h000010, "b2b_rd1");
    do_read (22'h000011, "b2b_rd2");
    idle_cyc(1);

    do_read(22'h3FF045, "alias");
    check("alias_err", 16'(err), 16'd0);
    idle_cyc(1);

    for (int i = 0; i < 24; i++) begin
      a   = 22'($urandom);
      d   = 16'($urandom);
      dsn = 2'($urandom);
      do_read (a, "rnd_pre");
      do_write(a, d, dsn);
      do_read (a, "rnd_post");
      if ($urandom_range(1, 0) == 1) idle_cyc(1);
    end
    check("rnd_err", 16'(err), 16'd0);

    // oen and wen low together: flag it, write nothing.
    addr_ph(22'h000045);
    pin.psram_oen = 1'b0;
    pin.psram_wen = 1'b0;
    pin.psram_dsn = 2'b00;
    pin.adq_in    = 16'hDEAD;
    @(negedge clk);
    check("both_low_err", 16'(err), 16'd1);
    pin.psram_oen = 1'b1;
    pin.psram_wen = 1'b1;
    pin.psram_dsn = 2'b11;
    @(negedge clk);
    idle_cyc(3);
    check("err_sticky", 16'(err), 16'd1);
    do_read(22'h000045, "both_low_nowr");
    idle_cyc(1);

    // Reset while a read is driving the bus.
    addr_ph(22'h000123);
    pin.psram_oen = 1'b0;
    repeat (RD_LAT + 2) @(negedge clk);
    check("pre_rst_oe", 16'(pin.adq_oe), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_oe",  16'(pin.adq_oe), 16'd0);
    check("async_rst_err", 16'(err),        16'd0);
    check("async_rst_out", pin.adq_out,     16'd0);
    @(negedge clk);
    idle_cyc(1);
    rst_n = 1'b1;
    idle_cyc(2);
    do_read(22'h000123, "post_rst");
    idle_cyc(1);

    // Both chip enables low.
    pin.psram_cen = 2'b00;
    @(negedge clk);
    check("dual_cen_err", 16'(err), 16'd1);
    idle_cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
